// File: rtl/issue_pair_latch_pkg.sv
// Shared widths, FSM state and per-lane issue bundle for issue_pair_latch.
package issue_pair_latch_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned MUXF_W  = 2;
  localparam int unsigned ALUF_W  = 4;

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Everything the execute stage needs for one lane.
  typedef struct packed {
    logic [DATA_W-1:0]  data_a;
    logic [DATA_W-1:0]  data_b;
    logic [DATA_W-1:0]  sign_ext_imm;
    logic [SHAMT_W-1:0] shamt;
    logic [MUXF_W-1:0]  mux_1_flag;
    logic [ALUF_W-1:0]  alu_function;
    logic [REG_W-1:0]   rd;
    logic               wr_en;
  } lane_t;

endpackage

// File: rtl/issue_pair_latch_if.sv
// Decode-side and execute-side signals of issue_pair_latch.
// master: decode/execute environment; slave: the issue latch.
interface issue_pair_latch_if;
  import issue_pair_latch_pkg::*;

  logic               in_valid;
  logic               in_lane2_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data_A_1, in_data_B_1, in_SignExtImm_1;
  logic [DATA_W-1:0]  in_data_A_2, in_data_B_2, in_SignExtImm_2;
  logic [SHAMT_W-1:0] in_shamt_1, in_shamt_2;
  logic [MUXF_W-1:0]  in_mux_1_flag_1, in_mux_1_flag_2;
  logic [ALUF_W-1:0]  in_Alu_function_1, in_Alu_function_2;
  logic [REG_W-1:0]   in_rs_1, in_rt_1, in_rd_1;
  logic [REG_W-1:0]   in_rs_2, in_rt_2, in_rd_2;
  logic               in_uses_rt_1, in_uses_rt_2;
  logic               in_wr_en_1, in_wr_en_2;
  logic [DATA_W-1:0]  alu_1_result;
  logic               ex_stall;
  logic               flush;
  logic               ex_valid_1, ex_valid_2;
  logic [DATA_W-1:0]  ex_data_A_1, ex_data_B_1, ex_SignExtImm_1;
  logic [DATA_W-1:0]  ex_data_A_2, ex_data_B_2, ex_SignExtImm_2;
  logic [SHAMT_W-1:0] ex_shamt_1, ex_shamt_2;
  logic [MUXF_W-1:0]  ex_mux_1_flag_1, ex_mux_1_flag_2;
  logic [ALUF_W-1:0]  ex_Alu_function_1, ex_Alu_function_2;
  logic [REG_W-1:0]   ex_rd_1, ex_rd_2;
  logic               ex_wr_en_1, ex_wr_en_2;

  modport master (
    output in_valid, in_lane2_valid,
    output in_data_A_1, in_data_B_1, in_SignExtImm_1, in_data_A_2, in_data_B_2, in_SignExtImm_2,
    output in_shamt_1, in_shamt_2, in_mux_1_flag_1, in_mux_1_flag_2,
    output in_Alu_function_1, in_Alu_function_2,
    output in_rs_1, in_rt_1, in_rd_1, in_rs_2, in_rt_2, in_rd_2,
    output in_uses_rt_1, in_uses_rt_2, in_wr_en_1, in_wr_en_2,
    output alu_1_result, ex_stall, flush,
    input  in_ready, ex_valid_1, ex_valid_2,
    input  ex_data_A_1, ex_data_B_1, ex_SignExtImm_1, ex_data_A_2, ex_data_B_2, ex_SignExtImm_2,
    input  ex_shamt_1, ex_shamt_2, ex_mux_1_flag_1, ex_mux_1_flag_2,
    input  ex_Alu_function_1, ex_Alu_function_2, ex_rd_1, ex_rd_2, ex_wr_en_1, ex_wr_en_2
  );

  modport slave (
    input  in_valid, in_lane2_valid,
    input  in_data_A_1, in_data_B_1, in_SignExtImm_1, in_data_A_2, in_data_B_2, in_SignExtImm_2,
    input  in_shamt_1, in_shamt_2, in_mux_1_flag_1, in_mux_1_flag_2,
    input  in_Alu_function_1, in_Alu_function_2,
    input  in_rs_1, in_rt_1, in_rd_1, in_rs_2, in_rt_2, in_rd_2,
    input  in_uses_rt_1, in_uses_rt_2, in_wr_en_1, in_wr_en_2,
    input  alu_1_result, ex_stall, flush,
    output in_ready, ex_valid_1, ex_valid_2,
    output ex_data_A_1, ex_data_B_1, ex_SignExtImm_1, ex_data_A_2, ex_data_B_2, ex_SignExtImm_2,
    output ex_shamt_1, ex_shamt_2, ex_mux_1_flag_1, ex_mux_1_flag_2,
    output ex_Alu_function_1, ex_Alu_function_2, ex_rd_1, ex_rd_2, ex_wr_en_1, ex_wr_en_2
  );

endinterface

// File: rtl/issue_pair_latch_pair_hazard_check.sv
// Intra-pair RAW detector: lane 2 reading lane 1's destination register.
module pair_hazard_check
  import issue_pair_latch_pkg::*;
(
  input  logic             lane2_valid_i,
  input  logic             wr_en_1_i,
  input  logic [REG_W-1:0] rd_1_i,
  input  logic [REG_W-1:0] rs_2_i,
  input  logic [REG_W-1:0] rt_2_i,
  input  logic             uses_rt_2_i,
  output logic             hazard_o,
  output logic             fwd_a_o,
  output logic             fwd_b_o
);

  logic producer;

  // r0 writes are discarded, so they never create a dependency.
  always_comb begin
    producer = lane2_valid_i && wr_en_1_i && (rd_1_i != '0);
    fwd_a_o  = producer && (rs_2_i == rd_1_i);
    fwd_b_o  = producer && uses_rt_2_i && (rt_2_i == rd_1_i);
    hazard_o = fwd_a_o || fwd_b_o;
  end

endmodule

// File: rtl/issue_pair_latch.sv
// Registered dual-lane issue stage. Optional feature macro: ISSUE_SPLIT_EN
// (intra-pair RAW detection, SPLIT state, hold register, lane-1 forwarding).
module issue_pair_latch
  import issue_pair_latch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  issue_pair_latch_if.slave  bus
);

  state_t state_q, state_d;
  logic   v1_q, v1_d, v2_q, v2_d;
  lane_t  l1_q, l1_d, l2_q, l2_d;
  lane_t  hold_q, hold_d;
  logic   fa_q, fa_d, fb_q, fb_d;
  lane_t  in1, in2;
  logic   hazard, fwd_a, fwd_b;

  assign in1 = '{bus.in_data_A_1, bus.in_data_B_1, bus.in_SignExtImm_1, bus.in_shamt_1,
                 bus.in_mux_1_flag_1, bus.in_Alu_function_1, bus.in_rd_1, bus.in_wr_en_1};
  assign in2 = '{bus.in_data_A_2, bus.in_data_B_2, bus.in_SignExtImm_2, bus.in_shamt_2,
                 bus.in_mux_1_flag_2, bus.in_Alu_function_2, bus.in_rd_2, bus.in_wr_en_2};

`ifdef ISSUE_SPLIT_EN
  pair_hazard_check u_hazard (
    .lane2_valid_i (bus.in_lane2_valid),
    .wr_en_1_i     (bus.in_wr_en_1),
    .rd_1_i        (bus.in_rd_1),
    .rs_2_i        (bus.in_rs_2),
    .rt_2_i        (bus.in_rt_2),
    .uses_rt_2_i   (bus.in_uses_rt_2),
    .hazard_o      (hazard),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
  );
  assign bus.in_ready = reset_n && (state_q == PAIR) && !bus.ex_stall && !bus.flush;
`else
  // Decode guarantees independent pairs; SPLIT is unreachable and folds away.
  assign hazard       = 1'b0;
  assign fwd_a        = 1'b0;
  assign fwd_b        = 1'b0;
  assign bus.in_ready = reset_n && !bus.ex_stall && !bus.flush;
`endif

  // Next state of FSM, output slots and hold register. Priority: flush, stall, SPLIT, accept.
  always_comb begin
    state_d = state_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    hold_d  = hold_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    if (bus.flush) begin
      state_d = PAIR;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      l1_d    = '0;
      l2_d    = '0;
      hold_d  = '0;
      fa_d    = 1'b0;
      fb_d    = 1'b0;
    end else if (!bus.ex_stall) begin
      unique case (state_q)
        SPLIT: begin
          // Held lane-2 instruction issues in lane 1, patched with the producer's result.
          l1_d = hold_q;
          if (fa_q) l1_d.data_a = bus.alu_1_result;
          if (fb_q) l1_d.data_b = bus.alu_1_result;
          v1_d    = 1'b1;
          v2_d    = 1'b0;
          l2_d    = '0;
          hold_d  = '0;
          fa_d    = 1'b0;
          fb_d    = 1'b0;
          state_d = PAIR;
        end
        default: begin
          if (bus.in_valid) begin
            v1_d = 1'b1;
            l1_d = in1;
            if (hazard) begin
              v2_d    = 1'b0;
              l2_d    = '0;
              hold_d  = in2;
              fa_d    = fwd_a;
              fb_d    = fwd_b;
              state_d = SPLIT;
            end else begin
              v2_d = bus.in_lane2_valid;
              l2_d = in2;
            end
          end else begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            l1_d = '0;
            l2_d = '0;
          end
        end
      endcase
    end
  end

  // State, output and hold registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAIR;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      l1_q    <= '0;
      l2_q    <= '0;
      hold_q  <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      hold_q  <= hold_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign bus.ex_valid_1        = v1_q;
  assign bus.ex_data_A_1       = l1_q.data_a;
  assign bus.ex_data_B_1       = l1_q.data_b;
  assign bus.ex_SignExtImm_1   = l1_q.sign_ext_imm;
  assign bus.ex_shamt_1        = l1_q.shamt;
  assign bus.ex_mux_1_flag_1   = l1_q.mux_1_flag;
  assign bus.ex_Alu_function_1 = l1_q.alu_function;
  assign bus.ex_rd_1           = l1_q.rd;
  assign bus.ex_wr_en_1        = l1_q.wr_en;
  assign bus.ex_valid_2        = v2_q;
  assign bus.ex_data_A_2       = l2_q.data_a;
  assign bus.ex_data_B_2       = l2_q.data_b;
  assign bus.ex_SignExtImm_2   = l2_q.sign_ext_imm;
  assign bus.ex_shamt_2        = l2_q.shamt;
  assign bus.ex_mux_1_flag_2   = l2_q.mux_1_flag;
  assign bus.ex_Alu_function_2 = l2_q.alu_function;
  assign bus.ex_rd_2           = l2_q.rd;
  assign bus.ex_wr_en_2        = l2_q.wr_en;

endmodule
